johnson_decoder: RTL
====================

Name: johnson_decoder

Overview:
- Receive end of the Johnson-counter interface: samples an N-bit Johnson code each cycle it is valid.
- Decodes the code to a binary state index and checks that each code legally follows the last one.
- Tracks lock and counts sequence errors.
- Sits downstream of johnson_counter; used for monitoring and sequencing logic that needs a binary phase.

Parameters:
- N, 4, Johnson code width; the sequence has 2N states (N >= 2).
- LOCK_CNT, 2, consecutive legal successors needed to declare lock (>= 1).
- ERR_W, 8, error counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- code  input  N  Johnson code from the counter.
- code_valid  input  1  code is sampled on this cycle.
- bin  output  $clog2(2N)  decoded state index 0..2N-1.
- bin_valid  output  1  bin holds a legal, freshly decoded code.
- locked  output  1  sequence is tracking correctly.
- err  output  1  one-cycle pulse on a sequence or illegal-code error.
- err_cnt  output  ERR_W  saturating error count.
- dir  output  1  1 = last accepted step was a down step; tied 0 without the optional feature.

Behaviour:
- Reference sequence for N=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then wrap. The next code is {code[N-2:0], ~code[N-1]}.
- Decode when code[N-1]==0: k = popcount(code).
- Decode when code[N-1]==1: k = 2N - popcount(code).
- A code is legal only if it equals the canonical pattern for the computed k. Any other code is illegal, e.g. 0101 or 1011.
- Reset (rst=0, async): bin=0, bin_valid=0, locked=0, err=0, err_cnt=0, dir=0. FSM goes to HUNT and the match counter clears. All outputs update together on the clock edge after release.
- Latency: outputs are registered and reflect the code sampled on the previous edge with code_valid=1. With code_valid=0, bin and bin_valid hold, err=0, and FSM and counters hold.
- Successor rule: new index == (prev index + 1) mod 2N. Wrap 2N-1 -> 0 is legal.
- Resync rule: code 0000 is always accepted, never an error. It covers the counter being reset mid-sequence.
  - In LOCKED it keeps lock.
  - In HUNT it sets the match counter to 0 and starts tracking from index 0.
- HUNT state:
  - A legal code that is a successor of the previous legal code increments the match counter.
  - When the counter reaches LOCK_CNT, the FSM moves to LOCKED and locked=1 on that same edge.
  - A legal non-successor sets the match counter to 0 and becomes the new reference.
  - An illegal code sets the match counter to 0, bin_valid=0, and err=1. In HUNT, err pulses only for illegal codes.
- LOCKED state:
  - Successor or resync: stay in LOCKED.
  - Legal non-successor: err=1, err_cnt++, go to HUNT, locked=0 on the same edge. bin still updates and bin_valid=1.
  - Illegal code: err=1, err_cnt++, bin_valid=0, bin holds, go to HUNT.
- err_cnt increments only on errors detected in LOCKED, plus illegal codes in either state. It saturates at all-ones and never wraps.
- First valid code after reset: no successor check, no error. If legal it becomes the reference.

Optional Feature:
- Macro: JOHNSON_DEC_DIR_EN.
- Defined:
  - A step of (prev - 1) mod 2N is also a legal successor and sets dir=1; a forward step sets dir=0.
  - A direction reversal while LOCKED is accepted, not an error, and does not drop lock.
  - In HUNT, the match counter counts only steps in the same direction as the previous step; a reversal sets the match counter to 1.
  - Resync to 0000 leaves dir unchanged.
- Not defined: a backward step is a non-successor, and dir is tied 0.

Test Plan:
- Reset then forward sequence: drive rst=0 for 10 time units, then release and drive 0000, 0001, 0011, 0111 with code_valid=1 each cycle (N=4, LOCK_CNT=2) -> bin = 0, 1, 2, 3 one cycle later; locked rises on the edge sampling 0011; err never pulses; err_cnt=0.
- Wrap: while locked, drive 1100, 1000, 0000, 0001 -> bin = 6, 7, 0, 1; locked stays 1; no err.
- Skipped state: while locked at 0011, drive 1111 -> err pulses one cycle, err_cnt=1, locked=0, bin=4. Then 1110, 1100 -> locked=1 again after 2 successors.
- Illegal code: while locked, drive 0101 -> bin_valid=0, bin holds its previous value, err=1, err_cnt increments, locked=0. Drive 1011 in HUNT -> err=1, err_cnt increments again.
- Mid-sequence restart and async reset:
  - While locked at 0111, drive 0000 -> no err and locked stays 1.
  - Then pull rst low between clock edges -> all outputs 0 immediately, without waiting for clk.
  - Force 255+ errors with ERR_W=8 -> err_cnt saturates at 8'hFF.
- With JOHNSON_DEC_DIR_EN, while locked at 0111, drive 0011, 0001 -> dir=1, bin = 2, 1, locked stays 1, no err. Without the macro, the same stimulus -> err on the 0011 step.

Source files
------------

// File: rtl/johnson_decoder_if.sv
// johnson_decoder_if: Johnson code stream in, decoded phase and status out.
interface johnson_decoder_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    localparam int BW = $clog2(2 * N);
    logic [N-1:0]     code;
    logic             code_valid;
    logic [BW-1:0]    bin;
    logic             bin_valid;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             dir;
    modport master (output code, code_valid, input bin, bin_valid, locked, err, err_cnt, dir);
    modport slave  (input code, code_valid, output bin, bin_valid, locked, err, err_cnt, dir);
endinterface

// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a Johnson code to its phase index and tracks sequence lock.
// Define JOHNSON_DEC_DIR_EN to also accept backward steps and report direction.
module johnson_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    johnson_decoder_if.slave  s
);
    localparam int BW = $clog2(2 * N);
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [N-1:0]  ALL  = '1;
    localparam logic [BW-1:0] LAST = BW'(2 * N - 1);
`ifdef JOHNSON_DEC_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    ref_idx, ref_n, bin_q, bin_n, k, nxt, prv;
    logic [ERR_W-1:0] ec, ec_n;
    logic             have, have_n, bv, bv_n, err_q, err_n, dir_q, dir_n;
    logic [N-1:0]     canon;
    logic             legal, fwd, bwd, same;
    int               pc, k_i;
    // Legal codes are a run of ones growing from the LSB, then shrinking from the LSB.
    always_comb begin
        pc    = $countones(s.code);
        k_i   = s.code[N-1] ? 2 * N - pc : pc;
        k     = BW'(k_i);
        canon = (k_i <= N) ? ~(ALL << k_i) : ALL << (k_i - N);
        legal = s.code == canon;
        nxt   = ref_idx == LAST ? '0 : ref_idx + BW'(1);
        prv   = ref_idx == '0 ? LAST : ref_idx - BW'(1);
        fwd   = k == nxt;
        bwd   = DIR_EN && k == prv;
        same  = bwd == dir_q;
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ref_n   = ref_idx;
        have_n  = have;
        bin_n   = bin_q;
        bv_n    = bv;
        err_n   = 1'b0;
        ec_n    = ec;
        dir_n   = dir_q;
        if (s.code_valid) begin
            if (!legal) begin
                bv_n = 1'b0;
                if (have) begin
                    err_n   = 1'b1;
                    ec_n    = &ec ? ec : ec + ERR_W'(1);
                    cnt_n   = '0;
                    state_n = HUNT;
                end
            end else begin
                bin_n  = k;
                bv_n   = 1'b1;
                ref_n  = k;
                have_n = 1'b1;
                // First code after reset and resync to phase 0 are never errors.
                if (!have || k == '0) begin
                    if (state == HUNT) cnt_n = '0;
                end else if (fwd || bwd) begin
                    dir_n = bwd;
                    if (state == HUNT) begin
                        cnt_n = same ? cnt + CW'(1) : CW'(1);
                        if (cnt_n == CW'(LOCK_CNT)) state_n = LOCKED;
                    end
                end else begin
                    cnt_n = '0;
                    if (state == LOCKED) begin
                        err_n   = 1'b1;
                        ec_n    = &ec ? ec : ec + ERR_W'(1);
                        state_n = HUNT;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HUNT;
            cnt     <= '0;
            ref_idx <= '0;
            have    <= 1'b0;
            bin_q   <= '0;
            bv      <= 1'b0;
            err_q   <= 1'b0;
            ec      <= '0;
            dir_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ref_idx <= ref_n;
            have    <= have_n;
            bin_q   <= bin_n;
            bv      <= bv_n;
            err_q   <= err_n;
            ec      <= ec_n;
            dir_q   <= dir_n;
        end
    end
    assign s.bin       = bin_q;
    assign s.bin_valid = bv;
    assign s.locked    = state == LOCKED;
    assign s.err       = err_q;
    assign s.err_cnt   = ec;
    assign s.dir       = dir_q;
endmodule
